// File: rtl/ctr_stage_scheduler.sv
// ctr_stage_scheduler
//   Sequences the three BCH decoder stages: syndrome calc (SC), key equation
//   solver (KES) and Chien search (CS). Each stage gets a one-cycle init
//   pulse, and the scheduler consumes that stage's done pulse. Frames overlap
//   through two one-deep handoff slots (SC->KES and KES->CS). A frame ID
//   travels with each frame, and completions are reported in acceptance order.
//
// Ports
//   clk                      clock, rising edge
//   in_Arst                  asynchronous active-high reset
//   in_en                    global enable; low blocks new init pulses only
//   in_frm_req               new frame available (held until ack)
//   out_frm_ack              frame accepted, identical to out_sc_init
//   out_sc_init/in_sc_done   SC start pulse / finish pulse
//   out_kes_init/in_kes_done KES start pulse / finish pulse
//   out_cs_init/in_cs_done   CS start pulse / finish pulse
//   out_sc_id/kes_id/cs_id   frame ID owned by each stage
//   out_frm_done(_id)        frame fully decoded, with its ID
//   out_busy                 any stage busy or any slot full (registered)
//   out_err                  sticky: done received while its stage was idle
module ctr_stage_scheduler #(
  parameter int unsigned ID_W = 4
) (
  input  logic            clk,
  input  logic            in_Arst,
  input  logic            in_en,
  input  logic            in_frm_req,
  output logic            out_frm_ack,
  output logic            out_sc_init,
  input  logic            in_sc_done,
  output logic            out_kes_init,
  input  logic            in_kes_done,
  output logic            out_cs_init,
  input  logic            in_cs_done,
  output logic [ID_W-1:0] out_sc_id,
  output logic [ID_W-1:0] out_kes_id,
  output logic [ID_W-1:0] out_cs_id,
  output logic            out_frm_done,
  output logic [ID_W-1:0] out_frm_done_id,
  output logic            out_busy,
  output logic            out_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } stage_t;

  stage_t          sc_st, kes_st, cs_st;
  logic            hsk_full, hkc_full;
  logic [ID_W-1:0] hsk_id, hkc_id;
  logic [ID_W-1:0] id_cnt;

  logic sc_start, kes_start, cs_start;
  logic sc_fin, kes_fin, cs_fin;
  logic spurious;

  always_comb begin
    sc_start  = in_en & in_frm_req & (sc_st == ST_IDLE) & ~hsk_full;
    kes_start = in_en & hsk_full & (kes_st == ST_IDLE) & ~hkc_full;
    cs_start  = in_en & hkc_full & (cs_st == ST_IDLE);
    sc_fin    = in_sc_done  & (sc_st  == ST_BUSY);
    kes_fin   = in_kes_done & (kes_st == ST_BUSY);
    cs_fin    = in_cs_done  & (cs_st  == ST_BUSY);
    spurious  = (in_sc_done  & (sc_st  == ST_IDLE)) |
                (in_kes_done & (kes_st == ST_IDLE)) |
                (in_cs_done  & (cs_st  == ST_IDLE));
  end

  always_ff @(posedge clk or posedge in_Arst) begin
    if (in_Arst) begin
      sc_st           <= ST_IDLE;
      kes_st          <= ST_IDLE;
      cs_st           <= ST_IDLE;
      hsk_full        <= 1'b0;
      hkc_full        <= 1'b0;
      hsk_id          <= '0;
      hkc_id          <= '0;
      id_cnt          <= '0;
      out_frm_ack     <= 1'b0;
      out_sc_init     <= 1'b0;
      out_kes_init    <= 1'b0;
      out_cs_init     <= 1'b0;
      out_sc_id       <= '0;
      out_kes_id      <= '0;
      out_cs_id       <= '0;
      out_frm_done    <= 1'b0;
      out_frm_done_id <= '0;
      out_busy        <= 1'b0;
      out_err         <= 1'b0;
    end else begin
      out_sc_init  <= sc_start;
      out_frm_ack  <= sc_start;
      out_kes_init <= kes_start;
      out_cs_init  <= cs_start;

      // SC stage; start needs IDLE and finish needs BUSY, so they never collide
      if (sc_start) begin
        sc_st     <= ST_BUSY;
        out_sc_id <= id_cnt;
        id_cnt    <= id_cnt + 1'b1;
      end else if (sc_fin) begin
        sc_st <= ST_IDLE;
      end

      // SC->KES slot: a fill wins over a drain so a same-edge handoff keeps
      // the newly finished frame
      if (sc_fin) begin
        hsk_full <= 1'b1;
        hsk_id   <= out_sc_id;
      end else if (kes_start) begin
        hsk_full <= 1'b0;
      end

      if (kes_start) begin
        kes_st     <= ST_BUSY;
        out_kes_id <= hsk_id;
      end else if (kes_fin) begin
        kes_st <= ST_IDLE;
      end

      if (kes_fin) begin
        hkc_full <= 1'b1;
        hkc_id   <= out_kes_id;
      end else if (cs_start) begin
        hkc_full <= 1'b0;
      end

      if (cs_start) begin
        cs_st     <= ST_BUSY;
        out_cs_id <= hkc_id;
      end else if (cs_fin) begin
        cs_st <= ST_IDLE;
      end

      out_frm_done <= cs_fin;
      if (cs_fin) begin
        out_frm_done_id <= out_cs_id;
      end

      out_busy <= (sc_st == ST_BUSY) | (kes_st == ST_BUSY) | (cs_st == ST_BUSY) |
                  hsk_full | hkc_full;

      if (spurious) begin
        out_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctr_stage_scheduler.sv
module tb_ctr_stage_scheduler;

  localparam int unsigned ID_W = 2;

  logic            clk = 1'b0;
  logic            in_Arst, in_en, in_frm_req;
  logic            in_sc_done, in_kes_done, in_cs_done;
  logic            out_frm_ack, out_sc_init, out_kes_init, out_cs_init;
  logic [ID_W-1:0] out_sc_id, out_kes_id, out_cs_id, out_frm_done_id;
  logic            out_frm_done, out_busy, out_err;

  int checks = 0;
  int errors = 0;

  ctr_stage_scheduler #(.ID_W(ID_W)) dut (
    .clk             (clk),
    .in_Arst         (in_Arst),
    .in_en           (in_en),
    .in_frm_req      (in_frm_req),
    .out_frm_ack     (out_frm_ack),
    .out_sc_init     (out_sc_init),
    .in_sc_done      (in_sc_done),
    .out_kes_init    (out_kes_init),
    .in_kes_done     (in_kes_done),
    .out_cs_init     (out_cs_init),
    .in_cs_done      (in_cs_done),
    .out_sc_id       (out_sc_id),
    .out_kes_id      (out_kes_id),
    .out_cs_id       (out_cs_id),
    .out_frm_done    (out_frm_done),
    .out_frm_done_id (out_frm_done_id),
    .out_busy        (out_busy),
    .out_err         (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Ends at a falling edge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    in_Arst = 1'b1;
    in_en = 1'b1; in_frm_req = 1'b0;
    in_sc_done = 1'b0; in_kes_done = 1'b0; in_cs_done = 1'b0;
    repeat (2) @(negedge clk);
    in_Arst = 1'b0;
  endtask

  task automatic test_reset();
    in_Arst = 1'b1;
    in_en = 1'b1; in_frm_req = 1'b0;
    in_sc_done = 1'b0; in_kes_done = 1'b0; in_cs_done = 1'b0;
    #1;
    checks++;
    if ({out_frm_ack, out_sc_init, out_kes_init, out_cs_init, out_frm_done, out_busy, out_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {out_frm_ack, out_sc_init, out_kes_init, out_cs_init, out_frm_done, out_busy, out_err});
    end
    checks++;
    if ({out_sc_id, out_kes_id, out_cs_id, out_frm_done_id} !== '0) begin
      errors++;
      $display("FAIL reset_ids: got %h expected 0", {out_sc_id, out_kes_id, out_cs_id, out_frm_done_id});
    end
    do_reset();
  endtask

  // req@0, sc_done@5, kes_done@10, cs_done@15
  task automatic test_single();
    do_reset();
    for (int cyc = 0; cyc <= 18; cyc++) begin
      checks++;
      if (out_sc_init !== (cyc == 1) || out_frm_ack !== (cyc == 1)) begin
        errors++;
        $display("FAIL single_sc_init cyc %0d: got init %b ack %b expected %b", cyc, out_sc_init, out_frm_ack, cyc == 1);
      end
      checks++;
      if (out_kes_init !== (cyc == 7)) begin
        errors++;
        $display("FAIL single_kes_init cyc %0d: got %b expected %b", cyc, out_kes_init, cyc == 7);
      end
      checks++;
      if (out_cs_init !== (cyc == 12)) begin
        errors++;
        $display("FAIL single_cs_init cyc %0d: got %b expected %b", cyc, out_cs_init, cyc == 12);
      end
      checks++;
      if (out_frm_done !== (cyc == 16)) begin
        errors++;
        $display("FAIL single_frm_done cyc %0d: got %b expected %b", cyc, out_frm_done, cyc == 16);
      end
      checks++;
      if (out_busy !== (cyc >= 2 && cyc <= 16)) begin
        errors++;
        $display("FAIL single_busy cyc %0d: got %b expected %b", cyc, out_busy, (cyc >= 2 && cyc <= 16));
      end
      if (cyc == 16) begin
        checks++;
        if (out_frm_done_id !== '0 || out_cs_id !== '0 || out_err !== 1'b0) begin
          errors++;
          $display("FAIL single_ids: got done_id %0d cs_id %0d err %b expected 0 0 0", out_frm_done_id, out_cs_id, out_err);
        end
      end
      in_frm_req  = (cyc == 0);
      in_sc_done  = (cyc == 5);
      in_kes_done = (cyc == 10);
      in_cs_done  = (cyc == 15);
      @(negedge clk);
    end
  endtask

  // Randomised traffic against an in-order frame model: the n-th accepted
  // frame carries ID n mod 2^ID_W through every stage and completes n-th.
  task automatic run_traffic(input string name, input int nframes, input int dmin,
                             input int dmax, input int kes_hold, input bit back2back);
    int  acc, kcnt, ccnt, dcnt, acc_mark;
    bit  busy [3];
    int  cnt  [3];
    bit  ini  [3];
    bit  dn   [3];
    bit  finished;
    logic [ID_W-1:0] exp_id;
    acc = 0; kcnt = 0; ccnt = 0; dcnt = 0; acc_mark = 0; finished = 1'b0;
    for (int s = 0; s < 3; s++) begin busy[s] = 1'b0; cnt[s] = 0; end
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ini[0] = out_sc_init; ini[1] = out_kes_init; ini[2] = out_cs_init;
      checks++;
      if (out_frm_ack !== out_sc_init) begin
        errors++;
        $display("FAIL %s_ack cyc %0d: got ack %b expected %b", name, cyc, out_frm_ack, out_sc_init);
      end
      for (int s = 0; s < 3; s++) begin
        if (ini[s]) begin
          checks++;
          if (busy[s]) begin
            errors++;
            $display("FAIL %s_double_init stage %0d cyc %0d: got init while busy expected none", name, s, cyc);
          end
          busy[s] = 1'b1;
          cnt[s]  = $urandom_range(dmax, dmin);
        end
      end
      if (out_sc_init) begin
        exp_id = ID_W'(acc);
        checks++;
        if (out_sc_id !== exp_id) begin
          errors++;
          $display("FAIL %s_sc_id cyc %0d: got %0d expected %0d", name, cyc, out_sc_id, exp_id);
        end
        acc++;
      end
      if (out_kes_init) begin
        exp_id = ID_W'(kcnt);
        checks++;
        if (out_kes_id !== exp_id || kcnt >= acc) begin
          errors++;
          $display("FAIL %s_kes_id cyc %0d: got %0d expected %0d", name, cyc, out_kes_id, exp_id);
        end
        kcnt++;
      end
      if (out_cs_init) begin
        exp_id = ID_W'(ccnt);
        checks++;
        if (out_cs_id !== exp_id || ccnt >= kcnt) begin
          errors++;
          $display("FAIL %s_cs_id cyc %0d: got %0d expected %0d", name, cyc, out_cs_id, exp_id);
        end
        ccnt++;
      end
      if (out_frm_done) begin
        exp_id = ID_W'(dcnt);
        checks++;
        if (out_frm_done_id !== exp_id || dcnt >= ccnt) begin
          errors++;
          $display("FAIL %s_done_id cyc %0d: got %0d expected %0d", name, cyc, out_frm_done_id, exp_id);
        end
        dcnt++;
      end
      checks++;
      if (acc - dcnt > 5) begin
        errors++;
        $display("FAIL %s_in_flight cyc %0d: got %0d expected <= 5", name, cyc, acc - dcnt);
      end
      if (kes_hold > 0 && cyc == 20) acc_mark = acc;
      if (kes_hold > 0 && cyc == kes_hold - 1) begin
        checks++;
        if (acc !== acc_mark || out_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_stall cyc %0d: got accepted %0d busy %b expected %0d 1", name, cyc, acc, out_busy, acc_mark);
        end
      end
      if (dcnt == nframes) begin
        finished = 1'b1;
        break;
      end
      for (int s = 0; s < 3; s++) begin
        dn[s] = 1'b0;
        if (busy[s]) begin
          if (cnt[s] == 0) begin
            if (!(s == 1 && cyc < kes_hold)) begin
              dn[s] = 1'b1;
              busy[s] = 1'b0;
            end
          end else begin
            cnt[s]--;
          end
        end
      end
      in_sc_done = dn[0]; in_kes_done = dn[1]; in_cs_done = dn[2];
      if (out_sc_init) in_frm_req = back2back && (acc < nframes);
      else if (!in_frm_req && acc < nframes) in_frm_req = back2back || ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    in_frm_req = 1'b0;
    in_sc_done = 1'b0; in_kes_done = 1'b0; in_cs_done = 1'b0;
    checks++;
    if (!finished || acc != nframes) begin
      errors++;
      $display("FAIL %s_complete: got %0d frames done (%0d accepted) expected %0d", name, dcnt, acc, nframes);
    end
    checks++;
    if (out_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_err: got %b expected 0", name, out_err);
    end
  endtask

  task automatic test_back_to_back();
    run_traffic("b2b", 6, 3, 3, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    run_traffic("bpress", 8, 0, 4, 50, 1'b0);
  endtask

  task automatic test_random();
    run_traffic("rand", 24, 0, 6, 0, 1'b0);
  endtask

  // KES busy from cycle 4; enable dropped 6..14, kes_done at 7.
  task automatic test_en_low();
    do_reset();
    for (int cyc = 0; cyc <= 20; cyc++) begin
      checks++;
      if (out_sc_init !== (cyc == 1) || out_kes_init !== (cyc == 4)) begin
        errors++;
        $display("FAIL en_sc_kes_init cyc %0d: got %b%b expected %b%b", cyc, out_sc_init, out_kes_init, cyc == 1, cyc == 4);
      end
      checks++;
      if (out_cs_init !== (cyc == 16)) begin
        errors++;
        $display("FAIL en_cs_init cyc %0d: got %b expected %b", cyc, out_cs_init, cyc == 16);
      end
      checks++;
      if (out_frm_done !== (cyc == 18)) begin
        errors++;
        $display("FAIL en_frm_done cyc %0d: got %b expected %b", cyc, out_frm_done, cyc == 18);
      end
      checks++;
      if (out_busy !== (cyc >= 2 && cyc <= 18)) begin
        errors++;
        $display("FAIL en_busy cyc %0d: got %b expected %b", cyc, out_busy, (cyc >= 2 && cyc <= 18));
      end
      in_en       = !(cyc >= 6 && cyc <= 14);
      in_frm_req  = (cyc == 0);
      in_sc_done  = (cyc == 2);
      in_kes_done = (cyc == 7);
      in_cs_done  = (cyc == 17);
      @(negedge clk);
    end
    in_en = 1'b1;
  endtask

  task automatic test_err_reset();
    do_reset();
    in_cs_done = 1'b1;          // cycle 0: CS idle
    @(negedge clk);
    checks++;
    if (out_err !== 1'b1 || out_frm_done !== 1'b0) begin
      errors++;
      $display("FAIL err_spurious: got err %b done %b expected 1 0", out_err, out_frm_done);
    end
    in_cs_done = 1'b0;
    in_frm_req = 1'b1;          // cycle 1
    @(negedge clk);
    checks++;
    if (out_sc_init !== 1'b1 || out_frm_done !== 1'b0) begin
      errors++;
      $display("FAIL err_sc_start: got init %b done %b expected 1 0", out_sc_init, out_frm_done);
    end
    in_frm_req = 1'b0;
    @(negedge clk);             // cycle 3: SC busy mid-frame
    checks++;
    if (out_busy !== 1'b1 || out_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got busy %b err %b expected 1 1", out_busy, out_err);
    end
    #2;
    in_Arst = 1'b1;
    #1;
    checks++;
    if ({out_frm_ack, out_sc_init, out_kes_init, out_cs_init, out_frm_done, out_busy, out_err} !== 7'b0 ||
        {out_sc_id, out_kes_id, out_cs_id, out_frm_done_id} !== '0) begin
      errors++;
      $display("FAIL err_async_reset: got flags %b ids %h expected all 0",
               {out_frm_ack, out_sc_init, out_kes_init, out_cs_init, out_frm_done, out_busy, out_err},
               {out_sc_id, out_kes_id, out_cs_id, out_frm_done_id});
    end
    @(negedge clk);
    in_Arst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_err !== 1'b0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL err_after_reset: got err %b busy %b expected 0 0", out_err, out_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_en_low();
    test_err_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
